// File: rtl/tx_packet_scheduler_pkg.sv
// tx_packet_scheduler_pkg: shared defaults, state encoding and sizing helpers for the transmit scheduler.
package tx_packet_scheduler_pkg;

    localparam int DEFAULT_PACKET_BUFFER_SIZE = 2048;
    localparam int DEFAULT_IFG_CYCLES         = 48;
    localparam int DEFAULT_TIMEOUT_CYCLES     = 4096;

    typedef enum logic [1:0] {S_IDLE, S_START, S_ACTIVE, S_GAP} state_e;

    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int imax(input int a, input int b);
        return a > b ? a : b;
    endfunction

endpackage

// File: rtl/tx_packet_scheduler_arb.sv
// round_robin_arb2: two-way round-robin grant, favouring the requester that did not win last.
module round_robin_arb2 (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic gnt_valid,
    output logic gnt_idx
);

    always_comb begin
        gnt_valid = req0 | req1;
        gnt_idx   = last_grant ? !req0 : req1;
    end

endmodule

// File: rtl/tx_packet_scheduler.sv
// tx_packet_scheduler: grants buffered-packet descriptors to the memory streamer, waits for
// transmit done, enforces the inter-frame gap and aborts stalled packets via a watchdog.
module tx_packet_scheduler
    import tx_packet_scheduler_pkg::*;
#(
    parameter int PACKET_BUFFER_SIZE = DEFAULT_PACKET_BUFFER_SIZE,
    parameter int RAM_SIZE           = PACKET_BUFFER_SIZE,
    parameter int IFG_CYCLES         = DEFAULT_IFG_CYCLES,
    parameter int TIMEOUT_CYCLES     = DEFAULT_TIMEOUT_CYCLES,
    localparam int AW = clog2(RAM_SIZE),
    localparam int CW = clog2(imax(TIMEOUT_CYCLES, IFG_CYCLES + 1))
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    input  logic [AW-1:0] req0_start,
    input  logic [AW-1:0] req0_end,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [AW-1:0] req1_start,
    input  logic [AW-1:0] req1_end,
    output logic          req1_ready,
    output logic          sfm_start,
    output logic [AW-1:0] read_start,
    output logic [AW-1:0] read_end,
    output logic          sfm_rst,
    input  logic          tx_done,
    output logic          pkt_done,
    output logic          pkt_abort,
    output logic          pkt_id,
    output logic          busy
);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last_grant_q, last_grant_d;
    logic          pkt_id_q, pkt_id_d;
    logic [AW-1:0] read_start_q, read_start_d, read_end_q, read_end_d;
    logic          sfm_start_q, sfm_start_d, sfm_rst_q, sfm_rst_d;
    logic          req0_ready_q, req0_ready_d, req1_ready_q, req1_ready_d;
    logic          pkt_done_q, pkt_done_d, pkt_abort_q, pkt_abort_d;
    logic          gnt_valid, gnt_idx;

    round_robin_arb2 u_arb (
        .req0      (req0_valid),
        .req1      (req1_valid),
        .last_grant(last_grant_q),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            pkt_id_q     <= 1'b0;
            read_start_q <= '0;
            read_end_q   <= '0;
            sfm_start_q  <= 1'b0;
            sfm_rst_q    <= 1'b0;
            req0_ready_q <= 1'b0;
            req1_ready_q <= 1'b0;
            pkt_done_q   <= 1'b0;
            pkt_abort_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            pkt_id_q     <= pkt_id_d;
            read_start_q <= read_start_d;
            read_end_q   <= read_end_d;
            sfm_start_q  <= sfm_start_d;
            sfm_rst_q    <= sfm_rst_d;
            req0_ready_q <= req0_ready_d;
            req1_ready_q <= req1_ready_d;
            pkt_done_q   <= pkt_done_d;
            pkt_abort_q  <= pkt_abort_d;
        end
    end

    // cnt_q is the watchdog in ACTIVE and the gap timer in GAP; both end on zero
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        pkt_id_d     = pkt_id_q;
        read_start_d = read_start_q;
        read_end_d   = read_end_q;
        case (state_q)
            S_IDLE: if (gnt_valid) begin
                state_d      = S_START;
                last_grant_d = gnt_idx;
                pkt_id_d     = gnt_idx;
                read_start_d = gnt_idx ? req1_start : req0_start;
                read_end_d   = gnt_idx ? req1_end : req0_end;
            end
            S_START: begin
                state_d = S_ACTIVE;
                cnt_d   = CW'(TIMEOUT_CYCLES - 2);
            end
            S_ACTIVE: if (tx_done || cnt_q == '0) begin
                state_d = IFG_CYCLES == 0 ? S_IDLE : S_GAP;
                cnt_d   = CW'(IFG_CYCLES - 1);
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
            S_GAP: if (cnt_q == '0) state_d = S_IDLE; else cnt_d = cnt_q - CW'(1);
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        sfm_start_d  = state_q == S_IDLE && gnt_valid;
        req0_ready_d = sfm_start_d && !gnt_idx;
        req1_ready_d = sfm_start_d && gnt_idx;
        pkt_done_d   = state_q == S_ACTIVE && tx_done;
        pkt_abort_d  = state_q == S_ACTIVE && !tx_done && cnt_q == '0;
        sfm_rst_d    = pkt_abort_d;
    end

    assign req0_ready = req0_ready_q;
    assign req1_ready = req1_ready_q;
    assign sfm_start  = sfm_start_q;
    assign read_start = read_start_q;
    assign read_end   = read_end_q;
    assign sfm_rst    = sfm_rst_q;
    assign pkt_done   = pkt_done_q;
    assign pkt_abort  = pkt_abort_q;
    assign pkt_id     = pkt_id_q;
    assign busy       = state_q != S_IDLE;

endmodule

// File: tb/tb_tx_packet_scheduler.sv
// tb_tx_packet_scheduler: directed checks of grant order, timing, gap, watchdog and reset behaviour.
module tb_tx_packet_scheduler;
    import tx_packet_scheduler_pkg::*;

    localparam int AW = clog2(DEFAULT_PACKET_BUFFER_SIZE);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req0_valid = 1'b0, req1_valid = 1'b0, tx_done = 1'b0;
    logic [AW-1:0] req0_start = '0, req0_end = '0, req1_start = '0, req1_end = '0;

    logic a_req0_ready, a_req1_ready, a_sfm_start, a_sfm_rst, a_pkt_done, a_pkt_abort, a_pkt_id, a_busy;
    logic [AW-1:0] a_read_start, a_read_end;
    logic b_req0_ready, b_req1_ready, b_sfm_start, b_sfm_rst, b_pkt_done, b_pkt_abort, b_pkt_id, b_busy;
    logic [AW-1:0] b_read_start, b_read_end;

    int checks = 0, errors = 0, cyc = 0, d = 0, t0 = 0;

    always #5 clk = ~clk;

    tx_packet_scheduler dut_a (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_start(req0_start), .req0_end(req0_end), .req0_ready(a_req0_ready),
        .req1_valid(req1_valid), .req1_start(req1_start), .req1_end(req1_end), .req1_ready(a_req1_ready),
        .sfm_start(a_sfm_start), .read_start(a_read_start), .read_end(a_read_end), .sfm_rst(a_sfm_rst),
        .tx_done(tx_done), .pkt_done(a_pkt_done), .pkt_abort(a_pkt_abort), .pkt_id(a_pkt_id), .busy(a_busy)
    );

    tx_packet_scheduler #(.IFG_CYCLES(0), .TIMEOUT_CYCLES(8)) dut_b (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_start(req0_start), .req0_end(req0_end), .req0_ready(b_req0_ready),
        .req1_valid(req1_valid), .req1_start(req1_start), .req1_end(req1_end), .req1_ready(b_req1_ready),
        .sfm_start(b_sfm_start), .read_start(b_read_start), .read_end(b_read_end), .sfm_rst(b_sfm_rst),
        .tx_done(tx_done), .pkt_done(b_pkt_done), .pkt_abort(b_pkt_abort), .pkt_id(b_pkt_id), .busy(b_busy)
    );

    typedef struct {
        logic r0, r1;
        logic [AW-1:0] s0, e0, s1, e1;
        logic id;
        logic [AW-1:0] xs, xe;
    } vec_t;
    vec_t vecs[6];

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [29:0] outs(input bit sel);
        return sel ? {b_req0_ready, b_req1_ready, b_sfm_start, b_sfm_rst, b_pkt_done, b_pkt_abort, b_pkt_id, b_busy, b_read_start, b_read_end}
                   : {a_req0_ready, a_req1_ready, a_sfm_start, a_sfm_rst, a_pkt_done, a_pkt_abort, a_pkt_id, a_busy, a_read_start, a_read_end};
    endfunction

    task automatic wait_start(input bit sel, input string nm);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!(sel ? b_sfm_start : a_sfm_start) && n < 300);
        check(nm, sel ? b_sfm_start : a_sfm_start, 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tx_done = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        vecs[0] = '{1, 1, 16, 80, 100, 200, 0, 16, 80};
        vecs[1] = '{1, 1, 1, 2, 300, 400, 1, 300, 400};
        vecs[2] = '{0, 1, 0, 0, 7, 7, 1, 7, 7};
        vecs[3] = '{1, 1, 0, 0, 50, 60, 0, 0, 0};
        vecs[4] = '{1, 0, 33, 44, 0, 0, 0, 33, 44};
        vecs[5] = '{1, 1, 10, 20, 2047, 0, 1, 2047, 0};

        tick();
        check("reset_a", outs(0), 0);
        check("reset_b", outs(1), 0);
        do_reset();

        // single request on the default-parameter instance
        req0_start = 16;
        req0_end = 80;
        req0_valid = 1'b1;
        t0 = cyc;
        tick();
        check("single_start", a_sfm_start, 1);
        check("single_rdy", {a_req1_ready, a_req0_ready}, 1);
        check("single_rs", a_read_start, 16);
        check("single_re", a_read_end, 80);
        check("single_id", a_pkt_id, 0);
        req0_valid = 1'b0;
        repeat (99) tick();
        check("single_predone", a_pkt_done, 0);
        check("single_busy_act", a_busy, 1);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check("single_done", a_pkt_done, 1);
        check("single_noabort", a_pkt_abort, 0);
        check("single_t", cyc - t0, 101);
        repeat (9) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check("stray_gap", a_pkt_done, 0);
        repeat (37) tick();
        check("gap_busy", a_busy, 1);
        tick();
        check("gap_idle", a_busy, 0);

        // contention: both held valid, grants alternate with IFG+2 spacing
        do_reset();
        req0_start = 10;
        req0_end = 20;
        req1_start = 30;
        req1_end = 40;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_start(0, "rr_start");
            check("rr_id", a_pkt_id, i % 2);
            check("rr_rdy", {a_req1_ready, a_req0_ready}, (i % 2) != 0 ? 2 : 1);
            check("rr_rs", a_read_start, (i % 2) != 0 ? 30 : 10);
            if (i > 0) check("rr_gap", cyc - d, 50);
            if (i < 4) begin
                repeat (5) tick();
                tx_done = 1'b1;
                d = cyc;
                tick();
                tx_done = 1'b0;
                check("rr_done", a_pkt_done, 1);
            end
        end

        // reset in ACTIVE right after a req0 grant: req0 must still win next
        repeat (3) tick();
        check("mid_busy", a_busy, 1);
        rst = 1'b1;
        tick();
        check("mid_quiet", outs(0), 0);
        rst = 1'b0;
        tick();
        check("mid_start", a_sfm_start, 1);
        check("mid_id", a_pkt_id, 0);
        check("mid_nodone", {a_pkt_done, a_pkt_abort, a_sfm_rst}, 0);

        // table of grants on the IFG=0 instance
        do_reset();
        for (int i = 0; i < 6; i++) begin
            req0_valid = vecs[i].r0;
            req1_valid = vecs[i].r1;
            req0_start = vecs[i].s0;
            req0_end = vecs[i].e0;
            req1_start = vecs[i].s1;
            req1_end = vecs[i].e1;
            wait_start(1, "tbl_start");
            if (i > 0) check("tbl_gap", cyc - d, 2);
            check("tbl_id", b_pkt_id, vecs[i].id);
            check("tbl_rs", b_read_start, vecs[i].xs);
            check("tbl_re", b_read_end, vecs[i].xe);
            check("tbl_rdy", {b_req1_ready, b_req0_ready}, vecs[i].id ? 2 : 1);
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            tick();
            tick();
            tx_done = 1'b1;
            d = cyc;
            tick();
            tx_done = 1'b0;
            check("tbl_done", b_pkt_done, 1);
            check("tbl_idle", b_busy, 0);
        end
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check("stray_idle", {b_pkt_done, b_pkt_abort, b_busy}, 0);
        tick();
        check("stray_idle2", {b_pkt_done, b_pkt_abort, b_busy}, 0);

        // watchdog timeout, then a same-cycle done/timeout race
        do_reset();
        req0_start = 5;
        req0_end = 9;
        req0_valid = 1'b1;
        tick();
        check("to_start", b_sfm_start, 1);
        t0 = cyc;
        req0_valid = 1'b0;
        repeat (7) tick();
        check("to_early", {b_pkt_abort, b_sfm_rst}, 0);
        tick();
        check("to_abort", {b_pkt_abort, b_sfm_rst}, 3);
        check("to_nodone", b_pkt_done, 0);
        check("to_t", cyc - t0, 8);
        check("to_idle", b_busy, 0);
        req1_start = 3;
        req1_end = 4;
        req1_valid = 1'b1;
        tick();
        check("to_pulse", {b_pkt_abort, b_sfm_rst}, 0);
        check("to_next", b_sfm_start, 1);
        check("to_next_id", b_pkt_id, 1);
        req1_valid = 1'b0;
        repeat (7) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check("sim_done", b_pkt_done, 1);
        check("sim_noabort", {b_pkt_abort, b_sfm_rst}, 0);
        tick();
        check("sim_after", {b_pkt_done, b_pkt_abort, b_sfm_rst}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
